// File: rtl/key_cnt_pkg.sv
// Shared definitions for the key counter / UART frame controller slice:
// state encoding, frame defaults and the frame byte selector.
package key_cnt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        WAIT = ST_WAIT
    } state_t;

    localparam logic [7:0] HEADER_DEF    = 8'hAA;
    localparam int         FRAME_LEN_DEF = 3;
    localparam int         IDX_W         = 2;

    // Byte order of a frame: header, snapshot value, header ^ value.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [7:0]       snap,
                                              input logic [7:0]       hdr);
        logic [7:0] b;
        case (idx)
            2'd0:    b = hdr;
            2'd1:    b = snap;
            2'd2:    b = hdr ^ snap;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/key_cnt_tx_ctrl_if.sv
// Byte-level handshake between the frame controller and the UART byte transmitter.
interface key_cnt_tx_ctrl_if;
    logic       Send_En;
    logic [7:0] Data_Byte;
    logic       Tx_Done;

    modport master (output Send_En, output Data_Byte, input Tx_Done);
    modport slave  (input Send_En, input Data_Byte, output Tx_Done);
endinterface

// File: rtl/key_cnt_tx_ctrl_cnt_updown.sv
// Wrapping up/down counter; simultaneous inc and dec cancel out.
module cnt_updown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         changed
);

    logic [W-1:0] cnt_r;

    assign changed = inc ^ dec;
    assign cnt     = cnt_r;

    // Counter register, wraps naturally in both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (inc && !dec) begin
            cnt_r <= cnt_r + W'(1);
        end else if (dec && !inc) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/key_cnt_tx_ctrl.sv
// Key press counter that reports each new value as a 3-byte frame through
// the UART byte transmitter; changes during a frame merge into one follow-up.
module key_cnt_tx_ctrl
    import key_cnt_pkg::*;
#(
    parameter int         CNT_W     = 8,
    parameter logic [7:0] HEADER    = HEADER_DEF,
    parameter int         FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 key1_flag,
    input  logic                 key2_flag,
    key_cnt_tx_ctrl_if.master    tx,
    output logic [CNT_W-1:0]     Cnt_Value,
    output logic                 Busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [CNT_W-1:0]   snap_r, snap_s;
    logic [7:0]         data_r, data_s;
    logic               send_en_r, send_en_s;
    logic               pending_r, pending_s;
    logic               busy_r;
    logic               frame_start_s;
    logic               changed_s;
    logic [CNT_W-1:0]   cnt_s;

    cnt_updown #(.W(CNT_W)) u_cnt (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .inc     (key1_flag),
        .dec     (key2_flag),
        .cnt     (cnt_s),
        .changed (changed_s)
    );

    // Next-state, byte selection and pending bookkeeping.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        snap_s        = snap_r;
        data_s        = data_r;
        send_en_s     = 1'b0;
        frame_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    state_s       = SEND;
                    idx_s         = '0;
                    snap_s        = cnt_s;
                    data_s        = HEADER;
                    send_en_s     = 1'b1;
                    frame_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: state_s = WAIT;
            WAIT: begin
                if (tx.Tx_Done) begin
                    if (idx_r < LAST_IDX) begin
                        idx_s     = idx_r + IDX_W'(1);
                        data_s    = frame_byte(idx_r + IDX_W'(1), snap_r, HEADER);
                        send_en_s = 1'b1;
                        state_s   = SEND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase

        // A change in the same cycle as a frame start keeps the request alive.
        if (changed_s) begin
            pending_s = 1'b1;
        end else if (frame_start_s) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r;
        end
    end

    // State, snapshot and registered handshake outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            snap_r    <= '0;
            data_r    <= 8'h00;
            send_en_r <= 1'b0;
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            snap_r    <= snap_s;
            data_r    <= data_s;
            send_en_r <= send_en_s;
            pending_r <= pending_s;
            busy_r    <= (state_s != IDLE);
        end
    end

    assign tx.Send_En   = send_en_r;
    assign tx.Data_Byte = data_r;
    assign Cnt_Value    = cnt_s;
    assign Busy         = busy_r;

endmodule

// File: tb/tb_key_cnt_tx_ctrl.sv
// Directed bench for key_cnt_tx_ctrl with a 100-cycle UART byte-time model.
module tb_key_cnt_tx_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       key1_flag = 1'b0;
    logic       key2_flag = 1'b0;
    logic [7:0] Cnt_Value;
    logic       Busy;

    int checks = 0;
    int fails  = 0;
    int send_cnt = 0;
    int base;

    key_cnt_tx_ctrl_if bus ();

    key_cnt_tx_ctrl dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .key1_flag (key1_flag),
        .key2_flag (key2_flag),
        .tx        (bus.master),
        .Cnt_Value (Cnt_Value),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // Count every Send_En pulse seen on a rising edge.
    always @(posedge Clk) begin
        if (bus.Send_En === 1'b1) send_cnt <= send_cnt + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        key1_flag = 1'b0;
        key2_flag = 1'b0;
        bus.Tx_Done = 1'b0;
        repeat (2) step();
        Rst_n = 1'b1;
        step();
    endtask

    // Called in the Send_En cycle; returns in the cycle after Tx_Done.
    task automatic tx_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_send"}, {31'd0, bus.Send_En}, 32'd1);
        chk({tag, "_data"}, {24'd0, bus.Data_Byte}, {24'd0, exp});
        step();
        chk({tag, "_pulse"}, {31'd0, bus.Send_En}, 32'd0);
        repeat (99) step();
        chk({tag, "_hold"}, {24'd0, bus.Data_Byte}, {24'd0, exp});
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
    endtask

    initial begin
        bus.Tx_Done = 1'b0;
        repeat (2) step();
        chk("rst_cnt",  {24'd0, Cnt_Value},     32'h00);
        chk("rst_send", {31'd0, bus.Send_En},   32'd0);
        chk("rst_data", {24'd0, bus.Data_Byte}, 32'h00);
        chk("rst_busy", {31'd0, Busy},          32'd0);

        // 1: single increment -> AA 01 AB
        do_reset();
        base = send_cnt;
        key1_flag = 1'b1;
        step();
        key1_flag = 1'b0;
        chk("t1_cnt",     {24'd0, Cnt_Value},   32'h01);
        chk("t1_early",   {31'd0, bus.Send_En}, 32'd0);
        step();
        tx_byte("t1_b0", 8'hAA);
        tx_byte("t1_b1", 8'h01);
        tx_byte("t1_b2", 8'hAB);
        chk("t1_idle", {31'd0, Busy}, 32'd0);
        repeat (5) step();
        chk("t1_nsend", send_cnt - base, 32'd3);

        // 2: decrement from zero wraps -> AA FF 55
        do_reset();
        key2_flag = 1'b1;
        step();
        key2_flag = 1'b0;
        chk("t2_cnt", {24'd0, Cnt_Value}, 32'hFF);
        step();
        tx_byte("t2_b0", 8'hAA);
        tx_byte("t2_b1", 8'hFF);
        tx_byte("t2_b2", 8'h55);
        chk("t2_idle", {31'd0, Busy}, 32'd0);

        // 3: both keys together cancel
        do_reset();
        base = send_cnt;
        key1_flag = 1'b1;
        key2_flag = 1'b1;
        step();
        key1_flag = 1'b0;
        key2_flag = 1'b0;
        repeat (6) step();
        chk("t3_cnt",   {24'd0, Cnt_Value}, 32'h00);
        chk("t3_busy",  {31'd0, Busy},      32'd0);
        chk("t3_nsend", send_cnt - base,    32'd0);

        // 4: three presses during byte 1 merge into one follow-up frame
        do_reset();
        base = send_cnt;
        key1_flag = 1'b1;
        step();
        key1_flag = 1'b0;
        step();
        tx_byte("t4_b0", 8'hAA);
        chk("t4_b1_send", {31'd0, bus.Send_En},   32'd1);
        chk("t4_b1_data", {24'd0, bus.Data_Byte}, 32'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            key1_flag = 1'b1;
            step();
            key1_flag = 1'b0;
        end
        chk("t4_cnt",  {24'd0, Cnt_Value},     32'h04);
        chk("t4_snap", {24'd0, bus.Data_Byte}, 32'h01);
        repeat (94) step();
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
        tx_byte("t4_b2", 8'hAB);
        chk("t4_gap_busy", {31'd0, Busy},        32'd0);
        chk("t4_gap_send", {31'd0, bus.Send_En}, 32'd0);
        step();
        tx_byte("t4_f2b0", 8'hAA);
        tx_byte("t4_f2b1", 8'h04);
        tx_byte("t4_f2b2", 8'hAE);
        repeat (5) step();
        chk("t4_idle",  {31'd0, Busy},   32'd0);
        chk("t4_nsend", send_cnt - base, 32'd6);

        // 5: reset mid-frame, then a late Tx_Done
        do_reset();
        key1_flag = 1'b1;
        step();
        key1_flag = 1'b0;
        step();
        tx_byte("t5_b0", 8'hAA);
        chk("t5_b1_data", {24'd0, bus.Data_Byte}, 32'h01);
        repeat (5) step();
        Rst_n = 1'b0;
        #1;
        chk("t5_rcnt",  {24'd0, Cnt_Value},     32'h00);
        chk("t5_rdata", {24'd0, bus.Data_Byte}, 32'h00);
        chk("t5_rbusy", {31'd0, Busy},          32'd0);
        step();
        step();
        Rst_n = 1'b1;
        step();
        base = send_cnt;
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
        repeat (5) step();
        chk("t5_nsend", send_cnt - base, 32'd0);
        chk("t5_busy",  {31'd0, Busy},   32'd0);

        // 6: spurious Tx_Done in IDLE and during SEND
        do_reset();
        base = send_cnt;
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
        step();
        chk("t6_idle_busy",  {31'd0, Busy},   32'd0);
        chk("t6_idle_nsend", send_cnt - base, 32'd0);
        key1_flag = 1'b1;
        step();
        key1_flag = 1'b0;
        step();
        chk("t6_b0_send", {31'd0, bus.Send_En},   32'd1);
        chk("t6_b0_data", {24'd0, bus.Data_Byte}, 32'hAA);
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
        chk("t6_no_adv",  {31'd0, bus.Send_En},   32'd0);
        chk("t6_hold",    {24'd0, bus.Data_Byte}, 32'hAA);
        chk("t6_busy",    {31'd0, Busy},          32'd1);
        repeat (99) step();
        bus.Tx_Done = 1'b1;
        step();
        bus.Tx_Done = 1'b0;
        tx_byte("t6_b1", 8'h01);
        tx_byte("t6_b2", 8'hAB);
        chk("t6_end_busy", {31'd0, Busy}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
